gf_mult_sequencer: RTL and testbench
====================================

// Module: gf_mult_sequencer
// PURPOSE
//  Iterative GF(2^WIDTH) multiplier controller. Reuses a single WIDTH-bit GF adder (bitwise XOR) datapath.
//  Sequences shift-and-add with polynomial reduction, one partial product per clock.
//  Sits between a requester (valid/ready in) and a consumer (valid/ready out) in the GField arithmetic path.
//  Constant-time: every operation takes exactly WIDTH iterations, whatever the operand values.
// PARAMETERS
//  WIDTH  8      field degree; operand/result width; legal range 2..16
//  POLY   8'h1B  low WIDTH bits of the irreducible reduction polynomial (x^WIDTH implicit); default = x^8+x^4+x^3+x+1
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand pair a/b valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  multiplicand; bit i = coefficient of x^i
//  b          in   WIDTH  multiplier; bit i = coefficient of x^i
//  out_valid  out  1      product valid
//  out_ready  in   1      consumer accepts product
//  product    out  WIDTH  a*b mod POLY; bit i = coefficient of x^i
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, internal regs/counter=0.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE:
//   - in_ready=1.
//   - On edge with in_valid=1: latch A<=a, B<=b, P<=0, cnt<=0, go to RUN.
//  RUN:
//   - in_ready=0. in_valid is ignored; a and b may change freely.
//   - Per edge: P<=P^(B[0]?A:0); A<=(A<<1)^(A[WIDTH-1]?POLY:0); B<=B>>1; cnt<=cnt+1.
//   - The edge that performs iteration cnt==WIDTH-1 loads product<=final P and goes to DONE.
//  DONE:
//   - out_valid=1; product is held stable while out_ready=0.
//   - On edge with out_ready=1: go to IDLE, out_valid<=0.
//  Timing:
//   - Accept edge k -> out_valid=1 after edge k+WIDTH.
//   - Minimum spacing between accepts is WIDTH+2 edges (no overlap; in_ready stays low in DONE).
//  Datapath:
//   - All arithmetic is XOR/shift. No carries. Result always fits in WIDTH bits.
//   - cnt is clog2(WIDTH) bits wide, or wider.
//  product:
//   - Holds its last value after the handshake until the next DONE.
//   - Only meaningful while out_valid=1.
//  Zero operands: no early exit; WIDTH cycles are still taken and the result is 0.
//  Reset mid-operation (RUN or DONE): the operation is abandoned, no output is produced, outputs return to reset values.
//  Simultaneous events: none possible. in and out handshakes never occur in the same state.
// TESTING
//  1. a=8'h57, b=8'h83, out_ready=1 -> product=8'hC1, out_valid asserted exactly 8 edges after accept.
//  2. a=8'h02, b=8'h80 -> product=8'h1B (reduction path); a=8'h53, b=8'hCA -> 8'h01.
//  3. a=8'hFF, b=8'h00 and a=8'h00, b=8'hFF -> product=8'h00 after 8 cycles.
//     a=8'h01, b=8'hA5 -> 8'hA5.
//  4. Back-pressure: out_ready=0 for 5 cycles after 8'h57*8'h13.
//     Expect out_valid held, product=8'hFE stable, in_ready=0.
//     Then raise out_ready -> IDLE the next edge.
//  5. Toggle in_valid and a/b during RUN -> ignored; result still matches the operands latched at accept.
//  6. Drop rst_n at iteration 4 of RUN -> out_valid=0, in_ready=1 immediately.
//     After release, a new op 8'h57*8'h83 -> 8'hC1.

Source files
------------

// File: rtl/gf_mult_sequencer.sv
// Iterative GF(2^WIDTH) multiplier: one shift-and-add step per clock with
// interleaved polynomial reduction, valid/ready handshakes on both sides.
// Constant latency of WIDTH iterations regardless of operand values.
module gf_mult_sequencer #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h1B)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             busy
);

  localparam int unsigned cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [cnt_w-1:0] last_iter = cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] product_d;
  logic [WIDTH-1:0] p_step;
  logic [WIDTH-1:0] a_step;

  // One iteration of the datapath: conditional add of A, then A*x mod POLY.
  always_comb begin
    p_step = p_q ^ ({WIDTH{b_q[0]}} & a_q);
    a_step = {a_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{a_q[WIDTH-1]}} & POLY);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath-next logic.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          p_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d   = p_step;
        a_d   = a_step;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + cnt_w'(1);
        if (cnt_q == last_iter) begin
          product_d = p_step;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product   <= product_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_gf_mult_sequencer.sv
// Self-checking bench for gf_mult_sequencer (WIDTH=8, POLY=0x1B).
module tb_gf_mult_sequencer;

  localparam int unsigned W = 8;
  localparam logic [W-1:0] POLY = 8'h1B;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] product;
  logic         busy;

  int n_cmp;
  int n_err;

  gf_mult_sequencer #(.WIDTH(W), .POLY(POLY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full carry-less product, then long division by x^8+POLY.
  function automatic logic [W-1:0] gf_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] acc;
    logic [2*W-1:0] modp;
    acc  = '0;
    modp = {{(W-1){1'b0}}, 1'b1, POLY};
    for (int i = 0; i < W; i++)
      if (y[i]) acc = acc ^ ((2*W)'(x) << i);
    for (int i = 2*W-2; i >= W; i--)
      if (acc[i]) acc = acc ^ (modp << (i - W));
    return acc[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full operation: accept, scramble inputs during RUN, measure latency,
  // optionally stall the consumer, then complete the output handshake.
  task automatic do_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input int stall, input logic [W-1:0] exp);
    int lat;
    out_ready = (stall == 0);
    check({tag, ".in_ready_pre"}, 16'(in_ready), 16'(1));
    a = xa;
    b = xb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check({tag, ".busy_run"}, 16'(busy), 16'(1));
    check({tag, ".in_ready_run"}, 16'(in_ready), 16'(0));
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = (lat < W - 1) ? 1'($urandom) : 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    in_valid = 1'b0;
    check({tag, ".latency"}, 16'(lat), 16'(W));
    check({tag, ".product"}, 16'(product), 16'(exp));
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        check({tag, ".hold_valid"}, 16'(out_valid), 16'(1));
        check({tag, ".hold_product"}, 16'(product), 16'(exp));
        check({tag, ".hold_in_ready"}, 16'(in_ready), 16'(0));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    check({tag, ".post_valid"}, 16'(out_valid), 16'(0));
    check({tag, ".post_in_ready"}, 16'(in_ready), 16'(1));
    check({tag, ".post_busy"}, 16'(busy), 16'(0));
    check({tag, ".post_product"}, 16'(product), 16'(exp));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", 16'(in_ready), 16'(1));
    check("rst.out_valid", 16'(out_valid), 16'(0));
    check("rst.busy", 16'(busy), 16'(0));
    check("rst.product", 16'(product), 16'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    do_op("t1", 8'h57, 8'h83, 0, 8'hC1);
    do_op("t2a", 8'h02, 8'h80, 0, 8'h1B);
    do_op("t2b", 8'h53, 8'hCA, 0, 8'h01);
    do_op("t3a", 8'hFF, 8'h00, 0, 8'h00);
    do_op("t3b", 8'h00, 8'hFF, 0, 8'h00);
    do_op("t3c", 8'h01, 8'hA5, 0, 8'hA5);
    do_op("t4", 8'h57, 8'h13, 5, 8'hFE);

    // Reset in the middle of RUN.
    a = 8'h57;
    b = 8'h83;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6.out_valid", 16'(out_valid), 16'(0));
    check("t6.in_ready", 16'(in_ready), 16'(1));
    check("t6.busy", 16'(busy), 16'(0));
    @(posedge clk); #1;
    check("t6.out_valid_hold", 16'(out_valid), 16'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("t6b", 8'h57, 8'h83, 0, 8'hC1);

    // Randomized operands and back-pressure against the reference model.
    for (int k = 0; k < 24; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (k == 0) ra = 8'h80;
      if (k == 1) rb = 8'hFF;
      do_op("rnd", ra, rb, int'($urandom_range(0, 3)), gf_ref(ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
